// File: rtl/dup_csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dup_csa_pkg
//  Description : Shared types, constants and helper functions for the
//                duplicated, self-checking carry-select adder pipeline.
//                - STAGE_MAX_W : widest sum a pipeline stage record can hold
//                - DEF_CNT_W   : default error-counter width
//                - stage_t     : one pipeline stage (valid, both chains,
//                                predicted parity, input-parity error)
//                - nseg()      : number of carry-select segments
//                - parity()    : XOR reduction (even parity bit)
//  Revision    : 1.0 - initial release
// ============================================================================
package dup_csa_pkg;

   // Stage records are sized for the widest supported adder. Bits above W
   // carry constants (s = 0, s_n = 1), so they are transparent to the
   // duplication and parity checks and are removed by synthesis.
   localparam int STAGE_MAX_W = 256;
   localparam int DEF_CNT_W   = 16;

   typedef struct packed {
      logic                   valid;
      logic [STAGE_MAX_W-1:0] s;
      logic [STAGE_MAX_W-1:0] s_n;
      logic                   cout;
      logic                   cout_n;
      logic                   ps;
      logic                   err_in;
   } stage_t;

   function automatic int nseg(input int w, input int seg);
      return w / seg;
   endfunction

   function automatic logic parity(input logic [STAGE_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/csa_segment.sv
`default_nettype none
// ============================================================================
//  Module      : csa_segment
//  Description : One SEG-bit carry-select segment computed twice: once in
//                true logic and once in complemented logic.
//  Ports       : a, b      - operand slices
//                c_in      - carry into the segment (true chain)
//                c_in_n    - inverted carry into the segment (compl. chain)
//                s, c_out  - true-chain sum and carry out
//                s_n       - complemented-chain sum (~sum)
//                c_out_n   - complemented-chain carry out (~carry)
//                carries   - carry into each bit, taken from the
//                            complemented chain and inverted back
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_segment #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           c_in,
   input  logic           c_in_n,
   output logic [SEG-1:0] s,
   output logic [SEG-1:0] s_n,
   output logic           c_out,
   output logic           c_out_n,
   output logic [SEG-1:0] carries
);

   // ---------------- true chain: both carry-in hypotheses ----------------
   logic [SEG-1:0] w_s0;
   logic [SEG-1:0] w_s1;
   logic           w_c0;
   logic           w_c1;

   assign {w_c0, w_s0} = {1'b0, a} + {1'b0, b};
   assign {w_c1, w_s1} = {1'b0, a} + {1'b0, b} + (SEG+1)'(1);

   assign s     = c_in ? w_s1 : w_s0;
   assign c_out = c_in ? w_c1 : w_c0;

   // ------------- complemented chain: both carry-in hypotheses -----------
   // Majority is self-dual and a 3-input XOR of inverted inputs is the
   // inverted XOR, so the ripple below produces ~sum and ~carry directly
   // from ~a, ~b and ~carry without ever touching true-polarity values.
   logic [SEG-1:0] w_na;
   logic [SEG-1:0] w_nb;
   logic [SEG:0]   w_nc0;   // hypothesis: true carry-in 0 (~carry-in 1)
   logic [SEG:0]   w_nc1;   // hypothesis: true carry-in 1 (~carry-in 0)
   logic [SEG-1:0] w_ns0;
   logic [SEG-1:0] w_ns1;

   assign w_na = ~a;
   assign w_nb = ~b;

   always_comb begin
      w_nc0    = '0;
      w_nc1    = '0;
      w_ns0    = '0;
      w_ns1    = '0;
      w_nc0[0] = 1'b1;
      w_nc1[0] = 1'b0;
      for (int i = 0; i < SEG; i++) begin
         w_ns0[i]   = w_na[i] ^ w_nb[i] ^ w_nc0[i];
         w_nc0[i+1] = (w_na[i] & w_nb[i]) | (w_na[i] & w_nc0[i]) | (w_nb[i] & w_nc0[i]);
         w_ns1[i]   = w_na[i] ^ w_nb[i] ^ w_nc1[i];
         w_nc1[i+1] = (w_na[i] & w_nb[i]) | (w_na[i] & w_nc1[i]) | (w_nb[i] & w_nc1[i]);
      end
   end

   // c_in_n = 1 means the true carry-in is 0
   assign s_n     = c_in_n ? w_ns0      : w_ns1;
   assign c_out_n = c_in_n ? w_nc0[SEG] : w_nc1[SEG];
   assign carries = ~(c_in_n ? w_nc0[SEG-1:0] : w_nc1[SEG-1:0]);

endmodule
`default_nettype wire

// File: rtl/dup_csa_checked_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dup_csa_checked_pipe
//  Description : Pipelined W-bit duplicated carry-select adder with parity
//                prediction, chain comparison and sticky error counting.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready, a, b, pa, pb, cin  - operand side
//                out_valid/out_ready, s, cout, ps      - result side
//                err_dup, err_par, err_in               - per-result flags
//                err_sticky, err_cnt, clr_err           - error accounting
//  Options     : DUP_CSA_FAULT_INJECT_EN adds inj_en / inj_bit, which flip
//                one bit of the complemented-chain sum on accept.
//  Revision    : 1.0 - initial release
// ============================================================================
module dup_csa_checked_pipe
   import dup_csa_pkg::*;
#(
   parameter int W     = 64,
   parameter int SEG   = 8,
   parameter int PIPE  = 2,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             pa,
   input  logic             pb,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     s,
   output logic             cout,
   output logic             ps,
   output logic             err_dup,
   output logic             err_par,
   output logic             err_in,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             clr_err
`ifdef DUP_CSA_FAULT_INJECT_EN
   ,
   input  logic                 inj_en,
   input  logic [$clog2(W)-1:0] inj_bit
`endif
);

   localparam int               NSEG    = nseg(W, SEG);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // ---------------------------- elaboration checks ----------------------
   if ((W % SEG) != 0) begin : g_bad_w_seg
      $error("dup_csa_checked_pipe: W must be a multiple of SEG");
   end
   if (PIPE < 1) begin : g_bad_pipe
      $error("dup_csa_checked_pipe: PIPE must be at least 1");
   end
   if (W > STAGE_MAX_W) begin : g_bad_w_max
      $error("dup_csa_checked_pipe: W exceeds STAGE_MAX_W");
   end

   // ----------------------------- duplicated datapath --------------------
   logic [NSEG:0] w_ct;     // true-chain segment carries
   logic [NSEG:0] w_cn;     // complemented-chain segment carries
   logic [W-1:0]  w_sum;
   logic [W-1:0]  w_sum_n;
   logic [W-1:0]  w_carry;  // carry into each bit, from the compl. chain

   assign w_ct[0] = cin;
   assign w_cn[0] = ~cin;

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      csa_segment #(.SEG(SEG)) u_seg (
         .a       (a[k*SEG +: SEG]),
         .b       (b[k*SEG +: SEG]),
         .c_in    (w_ct[k]),
         .c_in_n  (w_cn[k]),
         .s       (w_sum[k*SEG +: SEG]),
         .s_n     (w_sum_n[k*SEG +: SEG]),
         .c_out   (w_ct[k+1]),
         .c_out_n (w_cn[k+1]),
         .carries (w_carry[k*SEG +: SEG])
      );
   end

   logic [W-1:0] w_inj_mask;
`ifdef DUP_CSA_FAULT_INJECT_EN
   assign w_inj_mask = inj_en ? (W'(1) << inj_bit) : '0;
`else
   assign w_inj_mask = '0;
`endif

   // ----------------------------- stage-1 record -------------------------
   stage_t w_st1;

   always_comb begin
      w_st1            = '0;
      w_st1.valid      = in_valid;
      w_st1.s[W-1:0]   = w_sum;
      w_st1.s_n        = '1;
      w_st1.s_n[W-1:0] = w_sum_n ^ w_inj_mask;
      w_st1.cout       = w_ct[NSEG];
      w_st1.cout_n     = w_cn[NSEG];
      w_st1.ps         = pa ^ pb ^ (^w_carry);
      w_st1.err_in     = (pa != parity(STAGE_MAX_W'(a))) | (pb != parity(STAGE_MAX_W'(b)));
   end

   // ------------------------------- pipeline -----------------------------
   // A single global enable moves every stage together; bubbles are kept.
   stage_t r_pipe [1:PIPE];
   stage_t w_last;
   logic   w_en;

   assign w_last   = r_pipe[PIPE];
   assign w_en     = !w_last.valid || out_ready;
   assign in_ready = w_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i <= PIPE; i++) begin
            r_pipe[i] <= '0;
         end
      end else if (w_en) begin
         r_pipe[1] <= w_st1;
         for (int j = 2; j <= PIPE; j++) begin
            r_pipe[j] <= r_pipe[j-1];
         end
      end
   end

   // ------------------------------ result side ---------------------------
   assign out_valid = w_last.valid;
   assign s         = w_last.s[W-1:0];
   assign cout      = w_last.cout;
   assign ps        = w_last.ps;
   assign err_dup   = w_last.valid & ((w_last.s != ~w_last.s_n) | (w_last.cout != ~w_last.cout_n));
   assign err_par   = w_last.valid & (parity(w_last.s) != w_last.ps);
   assign err_in    = w_last.valid & w_last.err_in;

   // ---------------------------- error accounting ------------------------
   logic             w_cnt_evt;
   logic             r_sticky;
   logic [CNT_W-1:0] r_cnt;

   assign w_cnt_evt = out_valid && out_ready && (err_dup || err_par || err_in);

   // A clear coinciding with a counted error clears first, then counts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
         r_cnt    <= '0;
      end else if (clr_err) begin
         r_sticky <= w_cnt_evt;
         r_cnt    <= w_cnt_evt ? CNT_W'(1) : '0;
      end else if (w_cnt_evt) begin
         r_sticky <= 1'b1;
         if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign err_sticky = r_sticky;
   assign err_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dup_csa_checked_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dup_csa_checked_pipe
//  Description : Randomised self-checking bench. Expected results come from
//                plain 65-bit addition and a transaction-queue model of the
//                pipeline and error counter.
//  Options     : DUP_CSA_FAULT_INJECT_EN exercises the injection ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dup_csa_checked_pipe;

   localparam int W       = 64;
   localparam int SEG     = 8;
   localparam int PIPE    = 2;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     a = '0;
   logic [W-1:0]     b = '0;
   logic             pa = 1'b0;
   logic             pb = 1'b0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [W-1:0]     s;
   logic             cout;
   logic             ps;
   logic             err_dup;
   logic             err_par;
   logic             err_in;
   logic             err_sticky;
   logic [CNT_W-1:0] err_cnt;
   logic             clr_err = 1'b0;
   logic             inj_en = 1'b0;
   logic [5:0]       inj_bit = '0;

   dup_csa_checked_pipe #(.W(W), .SEG(SEG), .PIPE(PIPE), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .pa         (pa),
      .pb         (pb),
      .cin        (cin),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .s          (s),
      .cout       (cout),
      .ps         (ps),
      .err_dup    (err_dup),
      .err_par    (err_par),
      .err_in     (err_in),
      .err_sticky (err_sticky),
      .err_cnt    (err_cnt),
      .clr_err    (clr_err)
`ifdef DUP_CSA_FAULT_INJECT_EN
      ,
      .inj_en     (inj_en),
      .inj_bit    (inj_bit)
`endif
   );

   always #5 clk = ~clk;

   // ------------------------------ reference model -----------------------
   typedef struct {
      logic         v;
      logic [W-1:0] s;
      logic         cout;
      logic         ps;
      logic         ein;
      logic         epar;
      logic         edup;
   } txn_t;

   txn_t m_pipe [1:PIPE];
   int   m_cnt;
   logic m_sticky;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic txn_t make_txn(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                     input logic ipa, input logic ipb, input logic icin, input logic iinj);
      txn_t         t;
      logic [W:0]   full;
      logic [W-1:0] carries;
      full    = {1'b0, ia} + {1'b0, ib} + (W+1)'(icin);
      // carry into bit i is recoverable as a_i ^ b_i ^ s_i
      carries = ia ^ ib ^ full[W-1:0];
      t.v     = iv;
      t.s     = full[W-1:0];
      t.cout  = full[W];
      t.ps    = ipa ^ ipb ^ (^carries);
      t.ein   = (ipa != ^ia) || (ipb != ^ib);
      t.epar  = (^full[W-1:0]) != t.ps;
`ifdef DUP_CSA_FAULT_INJECT_EN
      t.edup  = iinj;
`else
      t.edup  = 1'b0;
      if (iinj) t.edup = 1'b0;
`endif
      return t;
   endfunction

   task automatic model_clear();
      for (int i = 1; i <= PIPE; i++) begin
         m_pipe[i] = make_txn(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      m_cnt    = 0;
      m_sticky = 1'b0;
   endtask

   task automatic check_outputs();
      check_val("out_valid", W'(out_valid), W'(m_pipe[PIPE].v));
      if (m_pipe[PIPE].v) begin
         check_val("s",       s,              m_pipe[PIPE].s);
         check_val("cout",    W'(cout),       W'(m_pipe[PIPE].cout));
         check_val("ps",      W'(ps),         W'(m_pipe[PIPE].ps));
         check_val("err_in",  W'(err_in),     W'(m_pipe[PIPE].ein));
         check_val("err_par", W'(err_par),    W'(m_pipe[PIPE].epar));
         check_val("err_dup", W'(err_dup),    W'(m_pipe[PIPE].edup));
      end
      check_val("err_sticky", W'(err_sticky), W'(m_sticky));
      check_val("err_cnt",    W'(err_cnt),    W'(m_cnt));
   endtask

   // One clock of stimulus: check what the DUT shows, drive the next inputs,
   // then advance the model to what the next rising edge should produce.
   task automatic cycle_io(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic ipa, input logic ipb, input logic icin,
                           input logic iord, input logic iclr, input logic iinj, input logic [5:0] ibit);
      logic en;
      logic hs;
      logic evt;
      txn_t h;
      @(negedge clk);
      check_outputs();
      in_valid  = iv;
      a         = ia;
      b         = ib;
      pa        = ipa;
      pb        = ipb;
      cin       = icin;
      out_ready = iord;
      clr_err   = iclr;
      inj_en    = iinj;
      inj_bit   = ibit;
      #1;
      h   = m_pipe[PIPE];
      en  = !h.v || iord;
      check_val("in_ready", W'(in_ready), W'(en));
      hs  = h.v && iord;
      evt = hs && (h.ein || h.epar || h.edup);
      if (iclr) begin
         m_cnt    = evt ? 1 : 0;
         m_sticky = evt;
      end else if (evt) begin
         m_sticky = 1'b1;
         if (m_cnt < CNT_MAX) m_cnt++;
      end
      if (en) begin
         for (int j = PIPE; j >= 2; j--) m_pipe[j] = m_pipe[j-1];
`ifdef DUP_CSA_FAULT_INJECT_EN
         m_pipe[1] = make_txn(iv, ia, ib, ipa, ipb, icin, iinj);
`else
         m_pipe[1] = make_txn(iv, ia, ib, ipa, ipb, icin, 1'b0);
`endif
      end
   endtask

   task automatic push(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin, input logic iord);
      cycle_io(1'b1, ia, ib, ^ia, ^ib, icin, iord, 1'b0, 1'b0, 6'd0);
   endtask

   task automatic idle(input logic iord, input logic iclr);
      cycle_io(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, iord, iclr, 1'b0, 6'd0);
   endtask

   // ---------------------------------- stimulus --------------------------
   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      model_clear();

      // power-on reset and reset-state checks
      #1 rst_n = 1'b0;
      @(posedge clk);
      #2;
      check_val("rst out_valid", W'(out_valid), '0);
      check_val("rst in_ready",  W'(in_ready),  W'(1));
      check_val("rst s",         s,             '0);
      check_val("rst ps",        W'(ps),        '0);
      check_val("rst err_cnt",   W'(err_cnt),   '0);
      check_val("rst flags",     W'({cout, err_dup, err_par, err_in, err_sticky}), '0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // all-ones plus one: wraps to zero with carry out
      push(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      // complementary operands with carry in, then back-to-back stream
      push(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1);
      push(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b1);
      push(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);

      // stall with two results in flight; offered operands must be refused
      push(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
      push(64'hCAFE_F00D_1234_5678, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) push(64'hBAD0_BAD0_BAD0_BAD0, 64'd7, 1'b0, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);

      // wrong pa, then clear the cycle after it is counted
      cycle_io(1'b1, 64'h3, 64'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b0);

`ifdef DUP_CSA_FAULT_INJECT_EN
      cycle_io(1'b1, 64'h0123_4567_89AB_CDEF, 64'h42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd37);
      cycle_io(1'b1, 64'h0123_4567_89AB_CDEF, 64'h42, ^64'h0123_4567_89AB_CDEF, ^64'h42, 1'b0,
               1'b1, 1'b0, 1'b1, 6'd37);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
`endif

      // saturation: a run of input-parity errors
      for (int i = 0; i < 10; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         cycle_io(1'b1, ra, rb, ~(^ra), ^rb, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
      end
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b1);

      // randomised traffic with backpressure, errors, clears and injection
      for (int i = 0; i < 500; i++) begin
         logic iv, iord, iclr, iinj, bpa, bpb;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: ra = '1;
            1: rb = ~ra;
            2: ra = '0;
            default: ;
         endcase
         iv   = ($urandom_range(0, 3) != 0);
         iord = ($urandom_range(0, 3) != 0);
         iclr = ($urandom_range(0, 19) == 0);
         iinj = ($urandom_range(0, 9) == 0);
         bpa  = ($urandom_range(0, 9) == 0);
         bpb  = ($urandom_range(0, 9) == 0);
         cycle_io(iv, ra, rb, (^ra) ^ bpa, (^rb) ^ bpb, 1'($urandom), iord, iclr, iinj,
                  6'($urandom_range(0, W-1)));
      end

      // reset while two results are in flight
      push(64'h1234, 64'h4321, 1'b0, 1'b1);
      push(64'h5678, 64'h8765, 1'b1, 1'b1);
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_val("midrst out_valid", W'(out_valid),  '0);
      check_val("midrst in_ready",  W'(in_ready),   W'(1));
      check_val("midrst err_cnt",   W'(err_cnt),    '0);
      check_val("midrst sticky",    W'(err_sticky), '0);
      model_clear();
      @(posedge clk);
      #2 rst_n = 1'b1;
      push(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1, 1'b1);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dup_csa_checked_pipe.md
Name: dup_csa_checked_pipe

Overview:
- Parametrised, pipelined successor of the 64-bit duplicated carry-select adder, with built-in self-checking.
- Computes a W-bit sum twice: a true-logic chain and a complemented-logic chain, built from uniform SEG-bit carry-select segments.
- Predicts sum parity from operand parities and carries, and compares both chains at the output.
- Sits in the datapath between operand registers and the result bus; flags transient or permanent faults via per-result error flags and a sticky counter.

Parameters:
- W, 64, operand and sum width; must be a multiple of SEG.
- SEG, 8, carry-select segment width.
- PIPE, 2, register stages from accept to result; minimum 1.
- CNT_W, 16, error-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operands
- a  in  W  operand A
- b  in  W  operand B
- pa  in  1  even parity of a
- pb  in  1  even parity of b
- cin  in  1  carry in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  W  sum from the true chain
- cout  out  1  carry out from the true chain
- ps  out  1  predicted sum parity
- err_dup  out  1  true and complemented chains disagree
- err_par  out  1  parity(s) differs from ps
- err_in  out  1  pa/pb inconsistent with a/b
- err_sticky  out  1  OR of all flagged errors since the last clear
- err_cnt  out  CNT_W  saturating count of erroneous results
- clr_err  in  1  synchronous clear of err_sticky and err_cnt

Behaviour:
- Reset is asynchronous, active-low, one clock.
- Reset values: all stage valids 0, so out_valid=0 and in_ready=1. s, cout, ps, err_dup, err_par, err_in = 0. err_sticky=0, err_cnt=0.
- Datapath per segment k (k = 0..W/SEG-1):
  - True chain: compute sums for carry-in 0 and carry-in 1, select with the true carry from segment k-1.
  - Complemented chain: computes ~sum and ~carry, selecting with its own inverted carry.
  - Segment 0 uses cin (true chain) and ~cin (complemented chain).
- Carry vector c[i] = carry into bit i from the complemented chain (inverted back), with c[0]=cin.
- ps = pa ^ pb ^ (XOR of c[W-1:0]).
- Operand parity check: err_in = (pa != ^a) | (pb != ^b).
- Arithmetic is unsigned modulo 2^W; cout holds bit W.
- Pipeline and stall rules:
  - Operands are captured into stage 1 on in_valid && in_ready.
  - Stage j advances to j+1 under a global enable en = !out_valid || out_ready; in_ready = en.
  - Bubbles are not compressed.
  - The sum is computed combinationally in stage 1. Stages 2..PIPE carry s, s_n, cout, cout_n, ps and err_in unchanged.
  - Latency is exactly PIPE cycles when out_ready=1.
- Checks are evaluated in the final stage and are visible while out_valid=1:
  - err_dup = (s != ~s_n) | (cout != ~cout_n).
  - err_par = (^s != ps).
- Error counting:
  - On out_valid && out_ready && (err_dup|err_par|err_in): err_sticky<=1 and err_cnt increments, saturating at 2^CNT_W-1.
  - A held result is counted once, on its handshake.
  - If clr_err coincides with a counted error, the clear wins, then the new event applies: err_cnt=1 and err_sticky=1.
- Output hold: with out_valid=1 and out_ready=0, every output holds stable and in_ready=0.
- Reset mid-operation discards all in-flight results; counters return to 0.

Optional Feature:
- Macro: DUP_CSA_FAULT_INJECT_EN.
- With the macro defined:
  - Extra ports inj_en (in, 1) and inj_bit (in, $clog2(W)).
  - On accept with inj_en=1, bit inj_bit of the complemented chain's stage-1 sum is flipped. This forces err_dup=1 and leaves s correct.
- Without the macro: the ports are absent and the chains are never perturbed.

Decomposition:
- Package dup_csa_pkg holds:
  - The function computing NSEG = W/SEG.
  - A stage struct typedef with fields valid, s, s_n, cout, cout_n, ps, err_in.
  - A parity function.
  - A localparam default for CNT_W.
- One sub-module, csa_segment, parametrised by SEG:
  - Inputs: a, b, c_in, c_in_n.
  - Outputs: s, s_n, c_out, c_out_n, and per-bit carries.
  - Instantiated NSEG times via generate.
- Elaboration check: assert W % SEG == 0 and PIPE >= 1.

Test Plan:
- Default params, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, correct parities, out_ready=1 -> after 2 cycles s=0, cout=1, ps=^0=0, all err flags 0.
- a=64'h0123_4567_89AB_CDEF, b=64'hFEDC_BA98_7654_3210, cin=1 -> s=0, cout=1, err_par=0; accept 3 back-to-back operands -> outputs in order, one per cycle.
- Stall: hold out_ready=0 for 5 cycles with 2 results in flight -> in_ready=0, s stable, no loss; release -> both results drain in order.
- Wrong pa (pa=1 with ^a=0) -> err_in=1 on that result, err_cnt 0->1, err_sticky=1; clr_err the next cycle -> err_cnt=0.
- With DUP_CSA_FAULT_INJECT_EN, inj_en=1, inj_bit=37 -> err_dup=1, s correct, err_cnt=1; CNT_W=2 with 5 errors -> err_cnt saturates at 3.
- Assert rst_n low while 2 results are in flight -> out_valid=0 immediately; after release the first new result arrives at latency PIPE.
